// File: rtl/sd_ram_arb.sv
// sd_ram_arb: arbiter for the single-port block data RAM that is shared by the
// SD data-line engine and the OTP/cipher engine.
// SD has default priority because DAT timing is rigid. A starvation counter
// forces an OTP win after MAX_WAIT consecutive denied OTP cycles.
//
// Ports:
//   iclk, irst           clock, asynchronous active-high reset
//   isd_*   / osd_*      SD requester: req/we/addr/wdata in; gnt (comb), rvalid, rdata out
//   iotp_*  / ootp_*     OTP requester, same protocol as SD
//   oram_*               registered RAM command (en, we, addr, wdata)
//   iram_rdata           synchronous RAM read data, valid 1 cycle after the en edge
//   ocnt_conflict        contention statistics
//
// Build option: define SD_ARB_STATS_EN to count cycles in which both requesters
// are active (16-bit, saturating). Without it ocnt_conflict is tied to zero.
module sd_ram_arb #(
  parameter int unsigned RAM_BLOCKS = 8,
  parameter int unsigned ADDR_W     = 9 + $clog2(RAM_BLOCKS),
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              isd_req,
  input  logic              isd_we,
  input  logic [ADDR_W-1:0] isd_addr,
  input  logic [7:0]        isd_wdata,
  output logic              osd_gnt,
  output logic              osd_rvalid,
  output logic [7:0]        osd_rdata,
  input  logic              iotp_req,
  input  logic              iotp_we,
  input  logic [ADDR_W-1:0] iotp_addr,
  input  logic [7:0]        iotp_wdata,
  output logic              ootp_gnt,
  output logic              ootp_rvalid,
  output logic [7:0]        ootp_rdata,
  output logic              oram_en,
  output logic              oram_we,
  output logic [ADDR_W-1:0] oram_addr,
  output logic [7:0]        oram_wdata,
  input  logic [7:0]        iram_rdata,
  output logic [15:0]       ocnt_conflict
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  logic              sd_act, otp_act, sd_win, otp_win;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              tag1_sd_q, tag1_sd_d, tag1_otp_q, tag1_otp_d;
  logic              sd_rvalid_q, sd_rvalid_d, otp_rvalid_q, otp_rvalid_d;

  // Arbitration: no grants while reset is held, OTP wins when alone or starved.
  always_comb begin
    sd_act  = isd_req & ~irst;
    otp_act = iotp_req & ~irst;
    otp_win = otp_act & (~sd_act | (wait_q == WAIT_LIM));
    sd_win  = sd_act & ~otp_win;
  end

  assign osd_gnt  = sd_win;
  assign ootp_gnt = otp_win;

  // Next-state: issue register, starvation counter, two-stage read owner tag.
  always_comb begin
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    wait_d       = '0;
    tag1_sd_d    = 1'b0;
    tag1_otp_d   = 1'b0;
    sd_rvalid_d  = tag1_sd_q;
    otp_rvalid_d = tag1_otp_q;

    if (otp_win) begin
      ram_en_d    = 1'b1;
      ram_we_d    = iotp_we;
      ram_addr_d  = iotp_addr;
      ram_wdata_d = iotp_wdata;
      tag1_otp_d  = ~iotp_we;
    end else if (sd_win) begin
      ram_en_d    = 1'b1;
      ram_we_d    = isd_we;
      ram_addr_d  = isd_addr;
      ram_wdata_d = isd_wdata;
      tag1_sd_d   = ~isd_we;
    end

    // Denied OTP cycles accumulate; saturate defensively at the limit.
    if (otp_act && !otp_win) begin
      wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      wait_q       <= '0;
      tag1_sd_q    <= 1'b0;
      tag1_otp_q   <= 1'b0;
      sd_rvalid_q  <= 1'b0;
      otp_rvalid_q <= 1'b0;
    end else begin
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      wait_q       <= wait_d;
      tag1_sd_q    <= tag1_sd_d;
      tag1_otp_q   <= tag1_otp_d;
      sd_rvalid_q  <= sd_rvalid_d;
      otp_rvalid_q <= otp_rvalid_d;
    end
  end

  assign oram_en     = ram_en_q;
  assign oram_we     = ram_we_q;
  assign oram_addr   = ram_addr_q;
  assign oram_wdata  = ram_wdata_q;
  assign osd_rvalid  = sd_rvalid_q;
  assign ootp_rvalid = otp_rvalid_q;
  // Read data is shared; rvalid alone tells each requester when it is theirs.
  assign osd_rdata   = iram_rdata;
  assign ootp_rdata  = iram_rdata;

`ifdef SD_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  // Saturating count of cycles with both requesters active.
  always_comb begin
    conflict_d = conflict_q;
    if (isd_req && iotp_req && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) conflict_q <= '0;
    else      conflict_q <= conflict_d;
  end

  assign ocnt_conflict = conflict_q;
`else
  assign ocnt_conflict = 16'd0;
`endif

endmodule

// File: tb/tb_sd_ram_arb.sv
// tb_sd_ram_arb: directed self-checking bench for sd_ram_arb with a behavioural
// synchronous RAM. Inputs change just after the falling edge; outputs are
// sampled 1 ns later, away from the rising edge.
module tb_sd_ram_arb;
  localparam int unsigned ADDR_W = 12;

  logic              iclk = 1'b0;
  logic              irst;
  logic              isd_req, isd_we, iotp_req, iotp_we;
  logic [ADDR_W-1:0] isd_addr, iotp_addr;
  logic [7:0]        isd_wdata, iotp_wdata;
  logic              osd_gnt, osd_rvalid, ootp_gnt, ootp_rvalid;
  logic [7:0]        osd_rdata, ootp_rdata;
  logic              oram_en, oram_we;
  logic [ADDR_W-1:0] oram_addr;
  logic [7:0]        oram_wdata;
  logic [7:0]        iram_rdata;
  logic [15:0]       ocnt_conflict;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  int n_chk  = 0;
  int n_pass = 0;
  int exp_conf;

  always #5 iclk = ~iclk;

  sd_ram_arb dut (
    .iclk(iclk), .irst(irst),
    .isd_req(isd_req), .isd_we(isd_we), .isd_addr(isd_addr), .isd_wdata(isd_wdata),
    .osd_gnt(osd_gnt), .osd_rvalid(osd_rvalid), .osd_rdata(osd_rdata),
    .iotp_req(iotp_req), .iotp_we(iotp_we), .iotp_addr(iotp_addr), .iotp_wdata(iotp_wdata),
    .ootp_gnt(ootp_gnt), .ootp_rvalid(ootp_rvalid), .ootp_rdata(ootp_rdata),
    .oram_en(oram_en), .oram_we(oram_we), .oram_addr(oram_addr), .oram_wdata(oram_wdata),
    .iram_rdata(iram_rdata), .ocnt_conflict(ocnt_conflict)
  );

  // Synchronous single-port RAM model.
  always @(posedge iclk) begin
    if (oram_en) begin
      if (oram_we) mem[oram_addr] <= oram_wdata;
      else         iram_rdata     <= mem[oram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic idle_inputs();
    isd_req = 1'b0; isd_we = 1'b0; isd_addr = '0; isd_wdata = '0;
    iotp_req = 1'b0; iotp_we = 1'b0; iotp_addr = '0; iotp_wdata = '0;
  endtask

  task automatic step();
    @(negedge iclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, {31'd0, osd_gnt | ootp_gnt}, 32'd0);
    check({tag, " rvalid"}, {31'd0, osd_rvalid | ootp_rvalid}, 32'd0);
    check({tag, " ram_en"}, {31'd0, oram_en}, 32'd0);
    check({tag, " ram_we"}, {31'd0, oram_we}, 32'd0);
    check({tag, " ram_addr"}, 32'(oram_addr), 32'd0);
    check({tag, " ram_wdata"}, 32'(oram_wdata), 32'd0);
    check({tag, " conflict"}, 32'(ocnt_conflict), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    mem[12'h010] = 8'h3C;
    mem[12'h020] = 8'hC3;
    iram_rdata = 8'h00;
    idle_inputs();
    irst = 1'b1;
    exp_conf = 0;

    // Reset state.
    step(); step(); #1;
    check_all_zero("reset");
    irst = 1'b0;
    step(); step();

    // SD-only back-to-back reads of 0x000..0x003.
    for (int k = 0; k < 7; k++) begin
      step();
      isd_req = (k < 4); isd_we = 1'b0; isd_addr = ADDR_W'(k);
      #1;
      check("sd_rd gnt", {31'd0, osd_gnt}, {31'd0, k < 4});
      check("sd_rd ram_en", {31'd0, oram_en}, {31'd0, (k >= 1 && k <= 4)});
      if (k >= 1 && k <= 4) check("sd_rd ram_addr", 32'(oram_addr), 32'(k - 1));
      check("sd_rd rvalid", {31'd0, osd_rvalid}, {31'd0, (k >= 2 && k <= 5)});
      check("sd_rd otp_rvalid", {31'd0, ootp_rvalid}, 32'd0);
      if (k >= 2 && k <= 5) check("sd_rd rdata", 32'(osd_rdata), 32'h10 + 32'(k - 2));
    end
    idle_inputs();

    // Continuous contention: SD x4 then OTP, repeated.
    for (int k = 0; k < 10; k++) begin
      step();
      isd_req = 1'b1; isd_addr = 12'h001;
      iotp_req = 1'b1; iotp_addr = 12'h002;
      #1;
      check("cont sd_gnt", {31'd0, osd_gnt}, {31'd0, (k % 5) != 4});
      check("cont otp_gnt", {31'd0, ootp_gnt}, {31'd0, (k % 5) == 4});
      exp_conf++;
    end
    step();
    idle_inputs();
    #1;
`ifdef SD_ARB_STATS_EN
    check("conflict count", 32'(ocnt_conflict), 32'(exp_conf));
`else
    check("conflict tied", 32'(ocnt_conflict), 32'd0);
`endif
    step(); step(); step();

    // OTP write 0xA5 to 0x1FF, then SD read of 0x1FF.
    for (int k = 0; k < 5; k++) begin
      step();
      idle_inputs();
      if (k == 0) begin iotp_req = 1'b1; iotp_we = 1'b1; iotp_addr = 12'h1FF; iotp_wdata = 8'hA5; end
      if (k == 1) begin isd_req = 1'b1; isd_addr = 12'h1FF; end
      #1;
      if (k == 0) check("raw otp_gnt", {31'd0, ootp_gnt}, 32'd1);
      if (k == 1) check("raw sd_gnt", {31'd0, osd_gnt}, 32'd1);
      if (k == 1) check("raw ram_we", {31'd0, oram_we}, 32'd1);
      check("raw otp_rvalid", {31'd0, ootp_rvalid}, 32'd0);
      check("raw sd_rvalid", {31'd0, osd_rvalid}, {31'd0, k == 3});
      if (k == 3) check("raw sd_rdata", 32'(osd_rdata), 32'hA5);
    end
    idle_inputs();

    // Interleaved reads: SD 0x010 on even cycles, OTP 0x020 on odd cycles.
    for (int k = 0; k < 6; k++) begin
      step();
      idle_inputs();
      if (k < 4 && (k % 2) == 0) begin isd_req = 1'b1; isd_addr = 12'h010; end
      if (k < 4 && (k % 2) == 1) begin iotp_req = 1'b1; iotp_addr = 12'h020; end
      #1;
      check("ilv sd_rvalid", {31'd0, osd_rvalid}, {31'd0, (k == 2 || k == 4)});
      check("ilv otp_rvalid", {31'd0, ootp_rvalid}, {31'd0, (k == 3 || k == 5)});
      if (k == 2 || k == 4) check("ilv sd_rdata", 32'(osd_rdata), 32'h3C);
      if (k == 3 || k == 5) check("ilv otp_rdata", 32'(ootp_rdata), 32'hC3);
    end
    idle_inputs();
    step(); step();

    // Reset one cycle after an SD read grant: the read must be discarded.
    step();
    isd_req = 1'b1; isd_addr = 12'h002;
    #1;
    check("rst sd_gnt", {31'd0, osd_gnt}, 32'd1);
    step();
    idle_inputs();
    irst = 1'b1;
    exp_conf = 0;
    #1;
    check_all_zero("in reset a");
    step(); #1;
    check_all_zero("in reset b");
    step();
    irst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("post rst sd_rvalid", {31'd0, osd_rvalid}, 32'd0);
      check("post rst ram_en", {31'd0, oram_en}, 32'd0);
      step();
    end

    // Arbitration resumes: fresh SD read of 0x003.
    for (int k = 0; k < 4; k++) begin
      isd_req = (k == 0); isd_addr = 12'h003;
      #1;
      if (k == 0) check("resume gnt", {31'd0, osd_gnt}, 32'd1);
      check("resume rvalid", {31'd0, osd_rvalid}, {31'd0, k == 2});
      if (k == 2) check("resume rdata", 32'(osd_rdata), 32'h13);
      step();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
